fifo_tx_serializer: RTL and testbench

//  Downstream drain stage for the 4-bit FIFO. Whenever the FIFO is non-empty and

---
 rtl/fifo_tx_serializer.sv | 144 ++++++++++++++
 tb/tb_fifo_tx_serializer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_serializer.sv
// -----------------------------------------------------------------------------
// fifo_tx_serializer
//
// Drain stage between the FIFO read port and the board-level serial pin.
// Whenever the FIFO is non-empty and transmission is enabled, one word is
// popped and sent as an asynchronous serial frame: start bit (0), DATA_W data
// bits LSB first, stop bit (1). Every bit lasts CLKS_PER_BIT clocks.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   tx_en       in   1 = allowed to start a new frame
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid one clk after fifo_rd is sampled
//   fifo_rd     out  read strobe (combinational, IDLE state only)
//   tx_out      out  serial line, idles high, registered
//   busy        out  1 while state != IDLE
//   frame_done  out  1-cycle pulse in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_tx_serializer #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_W  = (DATA_W > 1)       ? $clog2(DATA_W)       : 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [BAUD_W-1:0]   r_baud;
    logic                r_tx_out;
    logic                r_frame_done;

    logic                w_baud_last;
    logic                w_stop_pre_last;
    logic                w_fifo_rd;
    logic [DATA_W-1:0]   w_shift_next;

    assign w_baud_last     = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    // frame_done is registered, so it is armed one cycle before the final
    // stop-bit cycle in order to be high during that final cycle.
    assign w_stop_pre_last = (r_state == S_STOP) && (r_baud == BAUD_W'(CLKS_PER_BIT - 2));
    assign w_shift_next    = r_shift >> 1;

    // Pop request is only ever raised from IDLE; rst gates it so that the
    // strobe is low for the whole reset interval, even with the clock stopped.
    assign w_fifo_rd = (r_state == S_IDLE) && tx_en && !fifo_empty && !rst;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_baud       <= '0;
            r_tx_out     <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_stop_pre_last;
            case (r_state)
                S_IDLE: begin
                    r_baud   <= '0;
                    r_tx_out <= 1'b1;
                    if (w_fifo_rd) begin
                        r_state <= S_WAIT;
                    end
                end
                // Read data becomes valid during this cycle; capture it and
                // drive the start bit from the next edge on.
                S_WAIT: begin
                    r_shift  <= fifo_data;
                    r_baud   <= '0;
                    r_tx_out <= 1'b0;
                    r_state  <= S_START;
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_tx_out  <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                            r_tx_out <= 1'b1;
                            r_state  <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_shift   <= w_shift_next;
                            r_tx_out  <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    r_tx_out <= 1'b1;
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_baud   <= '0;
                    r_tx_out <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd    = w_fifo_rd;
    assign tx_out     = r_tx_out;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
module tb_fifo_tx_serializer;

    localparam int CPB       = 4;
    localparam int FRAME_LEN = 24;

    logic       clk        = 1'b0;
    logic       clk_run    = 1'b0;
    logic       rst        = 1'b0;
    logic       tx_en      = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [3:0] fifo_data  = 4'h0;
    logic       fifo_rd;
    logic       tx_out;
    logic       busy;
    logic       frame_done;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int rd_pulses   = 0;
    int last_rd_cyc = -100;

    logic [3:0] q[$];

    fifo_tx_serializer #(.DATA_W(4), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Stoppable clock: holds its level while clk_run is low.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Behavioural FIFO: data appears one clock after the read strobe is sampled.
    always @(posedge clk) begin : fifo_model
        logic [3:0] w;
        if (fifo_rd) begin
            rd_pulses++;
            last_rd_cyc = cyc;
            if (q.size() > 0) begin
                w = q.pop_front();
                fifo_data  <= w;
                fifo_empty <= (q.size() == 0);
            end
        end
        cyc++;
    end

    task automatic push(input logic [3:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    function automatic logic exp_bit(input logic [3:0] w, input int c);
        int idx;
        idx = (c - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 5) return 1'b1;
        return w[idx-1];
    endfunction

    // Waits for the start bit, then checks every cycle of one frame.
    // Returns the number of high cycles seen before the start bit.
    task automatic capture_frame(input logic [3:0] w, input string tag,
                                 input int drop_at, output int gap);
        int n;
        logic e;
        n = 0;
        @(negedge clk);
        while (tx_out !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        gap = n;
        checks++;
        if (tx_out !== 1'b0) begin
            errors++;
            $display("FAIL %s start_bit: tx_out=%b required 0 (timeout)", tag, tx_out);
            return;
        end
        checks++;
        if (cyc - last_rd_cyc != 2) begin
            errors++;
            $display("FAIL %s latency: %0d cycles from fifo_rd, required 2", tag, cyc - last_rd_cyc);
        end
        for (int c = 1; c <= FRAME_LEN; c++) begin
            if (c > 1) @(negedge clk);
            if (c == drop_at) tx_en = 1'b0;
            e = exp_bit(w, c);
            checks++;
            if (tx_out !== e) begin
                errors++;
                $display("FAIL %s tx_out cycle %0d: got %b required %b", tag, c, tx_out, e);
            end
            checks++;
            if (frame_done !== (c == FRAME_LEN)) begin
                errors++;
                $display("FAIL %s frame_done cycle %0d: got %b required %b", tag, c, frame_done, c == FRAME_LEN);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b required 1", tag, c, busy);
            end
        end
    endtask

    task automatic test_reset();
        // Clock stopped: async reset must take effect at once.
        #3 rst = 1'b1;
        #1;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: tx_out=%b busy=%b fifo_rd=%b frame_done=%b required 1 0 0 0",
                     tx_out, busy, fifo_rd, frame_done);
        end
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: tx_out=%b busy=%b fifo_rd=%b required 1 0 0",
                     tx_out, busy, fifo_rd);
        end
    endtask

    task automatic test_single();
        int gap;
        int rd0;
        rd0   = rd_pulses;
        tx_en = 1'b1;
        push(4'hA);
        capture_frame(4'hA, "single_A", 0, gap);
        @(negedge clk);
        checks++;
        if (rd_pulses - rd0 !== 1) begin
            errors++;
            $display("FAIL single_rd_count: got %0d required 1", rd_pulses - rd0);
        end
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: busy=%b tx_out=%b required 0 1", busy, tx_out);
        end
    endtask

    task automatic test_empty();
        int rd0;
        rd0   = rd_pulses;
        tx_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL empty cycle %0d: fifo_rd=%b tx_out=%b busy=%b required 0 1 0",
                         i, fifo_rd, tx_out, busy);
            end
        end
        checks++;
        if (rd_pulses != rd0) begin
            errors++;
            $display("FAIL empty_rd_count: got %0d required 0", rd_pulses - rd0);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        int rd0;
        rd0   = rd_pulses;
        tx_en = 1'b1;
        for (int i = 0; i < 8; i++) push(4'(i));
        for (int i = 0; i < 8; i++) begin
            capture_frame(4'(i), $sformatf("b2b_%0d", i), 0, gap);
            if (i > 0) begin
                checks++;
                if (gap != 2) begin
                    errors++;
                    $display("FAIL b2b_gap %0d: got %0d idle cycles required 2", i, gap);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (rd_pulses - rd0 != 8) begin
            errors++;
            $display("FAIL b2b_rd_count: got %0d required 8", rd_pulses - rd0);
        end
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b tx_out=%b required 0 1", busy, tx_out);
        end
    endtask

    task automatic test_tx_en_drop();
        int gap;
        int rd0;
        rd0   = rd_pulses;
        tx_en = 1'b1;
        push(4'h5);
        push(4'hC);
        // Drop tx_en in the middle of data bit 1 of word 5.
        capture_frame(4'h5, "drop_5", 10, gap);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL drop_hold cycle %0d: fifo_rd=%b tx_out=%b busy=%b required 0 1 0",
                         i, fifo_rd, tx_out, busy);
            end
        end
        checks++;
        if (rd_pulses - rd0 != 1) begin
            errors++;
            $display("FAIL drop_rd_count: got %0d required 1", rd_pulses - rd0);
        end
        tx_en = 1'b1;
        capture_frame(4'hC, "drop_C", 0, gap);
        checks++;
        if (rd_pulses - rd0 != 2) begin
            errors++;
            $display("FAIL drop_rd_count_after: got %0d required 2", rd_pulses - rd0);
        end
    endtask

    task automatic test_abort_reset();
        int gap;
        int n;
        int rd0;
        rd0   = rd_pulses;
        tx_en = 1'b1;
        push(4'h3);
        push(4'h9);
        n = 0;
        @(negedge clk);
        while (tx_out !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        // Advance to frame cycle 14: data bit 2 of 4'h3, which is 0.
        repeat (13) @(negedge clk);
        checks++;
        if (tx_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: tx_out=%b busy=%b required 0 1", tx_out, busy);
        end
        clk_run = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: tx_out=%b busy=%b fifo_rd=%b frame_done=%b required 1 0 0 0",
                     tx_out, busy, fifo_rd, frame_done);
        end
        #2 rst = 1'b0;
        clk_run = 1'b1;
        capture_frame(4'h9, "abort_next", 0, gap);
        checks++;
        if (rd_pulses - rd0 != 2) begin
            errors++;
            $display("FAIL abort_rd_count: got %0d required 2", rd_pulses - rd0);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL abort_final_idle: busy=%b fifo_rd=%b required 0 0", busy, fifo_rd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty();
        test_back_to_back();
        test_tx_en_drop();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
